// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the CPU data memory controller.
// The base address is also used by the CPU address decoder.
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_ACCESS = 2'b10,
    S_RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 data storage with per-byte write enables and a registered read.
// Separate read and write addresses so the controller can read at accept time.
module dmem_array #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // NOTE: the storage has no reset; a reset loop over every word would stop block-RAM inference.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the multi-cycle CPU MEM stage: req/ready handshake,
// optional wait states, byte/half/word lanes with load extension, align/range errors.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DMEM_BASE_ADDR),
  parameter int                DEPTH_WORDS = 512,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              busy,
  output logic              err_align,
  output logic              err_range
);

  localparam int                AW           = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] WINDOW_BYTES = ADDR_W'(DEPTH_WORDS * 4);
  localparam logic [3:0]        WAIT_INIT    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e r_state, w_next;

  logic          r_we;
  logic          r_sign;
  logic [1:0]    r_size;
  logic [1:0]    r_lane;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err_align;
  logic          r_err_range;

  logic [ADDR_W-1:0] w_offset;
  logic              w_err_align;
  logic              w_err_range;
  logic              w_err;
  logic              w_accept;
  logic              w_rd_en;
  logic              w_wr_en;
  logic [3:0]        w_be;
  logic [31:0]       w_wr_data;
  logic [31:0]       w_rd_word;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of the window.
  assign w_offset    = addr - BASE_ADDR;
  assign w_err_range = (w_offset >= WINDOW_BYTES);
  assign w_err_align = (size == 2'b11)
                     || ((size == SZ_HALF) && addr[0])
                     || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign w_err       = w_err_align || w_err_range;
  assign w_accept    = (r_state == S_IDLE) && req;

  // The array is read at the accepting edge, so its registered output is
  // already stable when the ACCESS edge registers the extended load result.
  assign w_rd_en = w_accept && !we && !w_err;
  assign w_wr_en = (r_state == S_ACCESS) && r_we;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  sz,
                                              input logic        sx);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: return {{24{sx & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sx & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_err)                w_next = S_RESP;
          else if (WAIT_CYCLES > 0) w_next = S_WAIT;
          else                      w_next = S_ACCESS;
        end
      end
      S_WAIT:   if (r_cnt == 4'd0) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_be      = 4'b0000;
    w_wr_data = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_be      = 4'b0001 << r_lane;
        w_wr_data = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be      = r_lane[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{r_wdata[15:0]}};
      end
      SZ_WORD: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_sign      <= 1'b0;
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_cnt       <= 4'd0;
      r_rdata     <= '0;
      r_err_align <= 1'b0;
      r_err_range <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we        <= we;
            r_sign      <= sign_ext;
            r_size      <= size;
            r_lane      <= w_offset[1:0];
            r_idx       <= w_offset[AW+1:2];
            r_wdata     <= wdata;
            r_cnt       <= WAIT_INIT;
            r_err_align <= w_err_align;
            r_err_range <= w_err_range;
            if (w_err) r_rdata <= '0;
          end
        end
        S_WAIT:   if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        S_ACCESS: if (!r_we) r_rdata <= load_extend(w_rd_word, r_lane, r_size, r_sign);
        S_RESP: begin
          r_err_align <= 1'b0;
          r_err_range <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_be    (w_be),
    .i_waddr (r_idx),
    .i_wdata (w_wr_data),
    .i_re    (w_rd_en),
    .i_raddr (w_offset[AW+1:2]),
    .o_rdata (w_rd_word)
  );

  assign rdata     = r_rdata;
  assign ready     = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign err_align = r_err_align;
  assign err_range = r_err_range;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one instance with no wait states, one with three.
// Each request pushes its expected response; a negedge monitor pops and compares.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int W0 = 0;
  localparam int W1 = 3;

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        req      [2];
  logic        we       [2];
  logic [1:0]  size     [2];
  logic        sign_ext [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic [31:0] rdata    [2];
  logic        ready    [2];
  logic        busy     [2];
  logic        err_align[2];
  logic        err_range[2];

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        ea;
    logic        er;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ready_cnt[2];
  logic [31:0] hold[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl #(.WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .size(size[0]),
    .sign_ext(sign_ext[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
    .ready(ready[0]), .busy(busy[0]), .err_align(err_align[0]), .err_range(err_range[0])
  );

  data_mem_ctrl #(.WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .size(size[1]),
    .sign_ext(sign_ext[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
    .ready(ready[1]), .busy(busy[1]), .err_align(err_align[1]), .err_range(err_range[1])
  );

  // Response monitor: every ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready[d] === 1'b1) begin
        ready_cnt[d]++;
        if (sb.size() == 0 || sb[0].d != d) begin
          checks++; failures++;
          $display("FAIL unexpected_ready dut%0d got=1 exp=0", d);
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if (rdata[d] !== mon_e.rdata) begin
            failures++;
            $display("FAIL rdata dut%0d got=%h exp=%h", d, rdata[d], mon_e.rdata);
          end
          checks++;
          if (err_align[d] !== mon_e.ea) begin
            failures++;
            $display("FAIL err_align dut%0d got=%b exp=%b", d, err_align[d], mon_e.ea);
          end
          checks++;
          if (err_range[d] !== mon_e.er) begin
            failures++;
            $display("FAIL err_range dut%0d got=%b exp=%b", d, err_range[d], mon_e.er);
          end
          checks++;
          if (cyc != mon_e.cyc) begin
            failures++;
            $display("FAIL latency dut%0d got_cycle=%0d exp_cycle=%0d", d, cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL timeout_%s got_pending=%0d exp_pending=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_ea, input logic exp_er);
    exp_t e;
    int   wc;
    wc   = (d == 0) ? W0 : W1;
    e.d  = d;
    e.ea = exp_ea;
    e.er = exp_er;
    if (exp_ea || exp_er) e.rdata = 32'h0;
    else if (w)           e.rdata = hold[d];
    else                  e.rdata = exp_rd;
    hold[d] = e.rdata;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; sign_ext[d] = sx; addr[d] = a; wdata[d] = wd;
    e.cyc = cyc + 1 + ((exp_ea || exp_er) ? 0 : wc + 1);
    sb.push_back(e);
    @(negedge clk);
    req[d] = 1'b0;
    wait_drain("access");
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    checks++;
    if (rdata[d] !== 32'h0 || ready[d] !== 1'b0 || busy[d] !== 1'b0 ||
        err_align[d] !== 1'b0 || err_range[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s dut%0d got rdata=%h ready=%b busy=%b ea=%b er=%b exp all zero",
               tag, d, rdata[d], ready[d], busy[d], err_align[d], err_range[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = SZ_WORD; sign_ext[d] = 1'b0;
      addr[d] = DMEM_BASE_ADDR; wdata[d] = 32'h0; hold[d] = 32'h0; ready_cnt[d] = 0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset_hold");
    check_idle_outputs(1, "reset_hold");
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check_idle_outputs(0, "reset_release");
    check_idle_outputs(1, "reset_release");
  endtask

  task automatic test_word();
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
  endtask

  task automatic test_byte();
    access(0, 1'b1, SZ_BYTE, 1'b0, 32'h1001_0009, 32'h0000_0080, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_BYTE, 1'b1, 32'h1001_0009, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
    access(0, 1'b0, SZ_BYTE, 1'b0, 32'h1001_0009, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_80EF, 1'b0, 1'b0);
  endtask

  task automatic test_half();
    access(0, 1'b1, SZ_HALF, 1'b0, 32'h1001_000A, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 32'h1234_80EF, 1'b0, 1'b0);
    access(0, 1'b0, SZ_HALF, 1'b1, 32'h1001_000A, 32'h0, 32'h0000_1234, 1'b0, 1'b0);
    access(0, 1'b0, SZ_HALF, 1'b1, 32'h1001_0008, 32'h0, 32'hFFFF_80EF, 1'b0, 1'b0);
    access(0, 1'b1, SZ_HALF, 1'b0, 32'h1001_0009, 32'h0000_5555, 32'h0, 1'b1, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 32'h1234_80EF, 1'b0, 1'b0);
    access(0, 1'b0, 2'b11,   1'b0, 32'h1001_0008, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_range();
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h1001_07FC, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1001_07FC, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0800, 32'h0, 32'h0, 1'b0, 1'b1);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1000_FFFC, 32'h0, 32'h0, 1'b0, 1'b1);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 32'h1234_80EF, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    access(0, 1'b1, SZ_BYTE, 1'b0, 32'h1001_0020, 32'hFFFF_FF11, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, SZ_BYTE, 1'b0, 32'h1001_0021, 32'h0000_0022, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, SZ_BYTE, 1'b0, 32'h1001_0022, 32'h0000_0033, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, SZ_BYTE, 1'b0, 32'h1001_0023, 32'h0000_0044, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h1001_0020, 32'h0, 32'h4433_2211, 1'b0, 1'b0);
  endtask

  task automatic test_wait_states();
    exp_t e;
    int   r0;
    int   nb;
    access(1, 1'b1, SZ_WORD, 1'b0, 32'h1001_0010, 32'h0102_0304, 32'h0, 1'b0, 1'b0);
    r0 = ready_cnt[1];
    nb = 0;
    e.d = 1; e.rdata = 32'h0102_0304; e.ea = 1'b0; e.er = 1'b0;
    hold[1] = e.rdata;
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; size[1] = SZ_WORD; sign_ext[1] = 1'b0;
    addr[1] = 32'h1001_0010; wdata[1] = 32'h0;
    e.cyc = cyc + 1 + W1 + 1;
    sb.push_back(e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy[1] === 1'b1) nb++;
      if (i == 0) req[1] = 1'b0;
      if (i == 1) begin
        req[1] = 1'b1; we[1] = 1'b1; wdata[1] = 32'hFFFF_FFFF;
      end
      if (i == 2) begin
        req[1] = 1'b0; we[1] = 1'b0;
      end
    end
    wait_drain("wait_load");
    checks++;
    if (nb != W1 + 2) begin
      failures++;
      $display("FAIL busy_cycles dut1 got=%0d exp=%0d", nb, W1 + 2);
    end
    checks++;
    if (ready_cnt[1] - r0 != 1) begin
      failures++;
      $display("FAIL ignored_req dut1 got_ready_pulses=%0d exp=1", ready_cnt[1] - r0);
    end
  endtask

  task automatic test_reset_in_wait();
    int r0;
    r0 = ready_cnt[1];
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_WORD; addr[1] = 32'h1001_0010;
    wdata[1] = 32'hCAFE_F00D;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL busy_before_reset dut1 got=%b exp=1", busy[1]);
    end
    @(posedge clk);
    #2 rst[1] = 1'b1;
    #1 check_idle_outputs(1, "async_reset");
    @(negedge clk);
    rst[1] = 1'b0;
    hold[1] = 32'h0;
    repeat (6) @(negedge clk);
    checks++;
    if (ready_cnt[1] != r0) begin
      failures++;
      $display("FAIL aborted_store_ready dut1 got=%0d exp=%0d", ready_cnt[1] - r0, 0);
    end
    access(1, 1'b0, SZ_WORD, 1'b0, 32'h1001_0010, 32'h0, 32'h0102_0304, 1'b0, 1'b0);
    access(1, 1'b0, SZ_WORD, 1'b0, 32'h1001_0800, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_range();
    test_back_to_back();
    test_wait_states();
    test_reset_in_wait();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
